lpc_capture_fifo: RTL and testbench
===================================

Name: lpc_capture_fifo

Overview:
Parametrised capture stage between the LPC cycle decoder and the UART transmitter. It replaces the fixed lpc2mem + buffer + ringbuffer + mem2serial chain with one single-clock block that:
- filters decoded LPC cycles by type
- packs each accepted cycle into a fixed-length byte record
- queues records in a configurable-depth FIFO
- streams them out one byte at a time over a valid/ready handshake

Address width, FIFO depth and cycle filter are generalised. Explicit drop accounting is new.

Parameters:
ADDR_BYTES, 4, number of address bytes per record (1..4); uses in_addr[8*ADDR_BYTES-1:0]
DEPTH_BITS, 4, FIFO holds 2**DEPTH_BITS records
TYPE_MASK, 16'hFFFF, bit i set = accept cycles with in_cyctype == i

Ports:
clock  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-low; clears all state
capture_en  input  1  0 = ignore in_latch entirely (not counted as drop)
in_cyctype  input  4  LPC CYCTYPE+DIR nibble of the decoded cycle
in_addr  input  32  decoded address
in_data  input  8  decoded data byte
in_latch  input  1  one-cycle strobe, in_* valid
out_data  output  8  current record byte
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts byte when out_valid && out_ready at edge
empty  output  1  FIFO empty and serializer idle
overflow  output  1  lost flag pending (drop since last pushed record)
drop_count  output  16  records dropped since reset, saturates at 16'hFFFF

Behaviour:
- Reset (reset=0, async) outputs:
  - out_valid=0, out_data=0, empty=1, overflow=0, drop_count=0
  - FIFO pointers and count cleared; serializer idle
  - Applies immediately, even mid-record. The partial record is discarded.
- Record length REC_LEN = ADDR_BYTES+2 (+2 with timestamp). Byte order:
  - byte0 = header {lost, 3'b000, cyctype}
  - address bytes, MSB first
  - data byte
- Accept condition: capture_en && in_latch && TYPE_MASK[in_cyctype].
  - Filtered or disabled strobes have no effect at all.
- Push:
  - When accepted and count < 2**DEPTH_BITS (count sampled at start of cycle), write the record at the write pointer; count+1.
  - A pop in the same cycle does not free space for that cycle's push.
- Drop:
  - When accepted and the FIFO is full: record discarded, lost flag set, drop_count +1 (saturating).
- Lost flag:
  - The header bit7 of the next pushed record = lost flag value; the flag clears on that push.
  - overflow output = lost flag.
- Pointers wrap modulo 2**DEPTH_BITS; count is DEPTH_BITS+1 bits.
- Serializer states: IDLE, SEND.
  - IDLE and count>0: at the edge, load the head record into the shift register, pop the FIFO (count-1), byte index=0, out_valid=1, out_data=header. Go to SEND.
  - SEND: on out_valid && out_ready, advance index and present the next byte.
    - After the last byte is accepted: if count>0, load the next record in the same edge (back-to-back, no bubble); else out_valid=0 and go to IDLE.
  - out_data and out_valid are stable while out_valid && !out_ready.
- Latency: strobe sampled at edge N -> entry pushed at N. If the serializer is idle, header appears on out_data after edge N+1.
- Push and pop in the same cycle: count unchanged.
- Effective capacity: 2**DEPTH_BITS in FIFO + 1 in serializer.
- empty = (count==0) && IDLE.

Optional Feature:
- Macro LPC_CAPTURE_TIMESTAMP_EN.
  - Defined: 16-bit free-running counter (reset 0, +1 every clock, wraps). Its value at the accepting edge is appended MSB first after the data byte; REC_LEN = ADDR_BYTES+4.
  - Undefined: no counter, REC_LEN = ADDR_BYTES+2.

Test Plan:
- Defaults, out_ready=1, one strobe cyctype=4'h2 addr=32'h00000080 data=8'h5A -> bytes 02 00 00 00 80 5A on consecutive cycles, first byte after strobe edge+1; then empty=1.
- TYPE_MASK=16'h0004; strobes cyctype=1 then cyctype=2 -> only the cyctype=2 record emitted; drop_count=0.
- DEPTH_BITS=2, out_ready=0, 7 accepted strobes -> 5 held, drop_count=2, overflow=1. Release out_ready, then one more strobe: first 5 headers have bit7=0, 6th header bit7=1, overflow returns to 0.
- Random out_ready toggling over 3 back-to-back records -> byte sequence identical to the no-stall case; out_data never changes while stalled.
- Assert reset during byte 3 of a record -> out_valid=0 and empty=1 immediately; drop_count=0; next strobe after release produces a clean record.
- LPC_CAPTURE_TIMESTAMP_EN, ADDR_BYTES=2, strobe at counter 16'h0123 -> record 02 00 80 5A 01 23 (6 bytes).

Source files
------------

// File: rtl/lpc_capture_fifo.sv
// rtl/lpc_capture_fifo.sv - LPC cycle filter, record FIFO and byte-wide record serializer
// Optional feature: define LPC_CAPTURE_TIMESTAMP_EN to append a 16-bit cycle timestamp to every record.
module lpc_capture_fifo #(
  parameter int          ADDR_BYTES = 4,
  parameter int          DEPTH_BITS = 4,
  parameter logic [15:0] TYPE_MASK  = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        capture_en,
  input  logic [3:0]  in_cyctype,
  input  logic [31:0] in_addr,
  input  logic [7:0]  in_data,
  input  logic        in_latch,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        empty,
  output logic        overflow,
  output logic [15:0] drop_count
);

`ifdef LPC_CAPTURE_TIMESTAMP_EN
  localparam int TS_BYTES = 2;
`else
  localparam int TS_BYTES = 0;
`endif
  localparam int REC_LEN  = ADDR_BYTES + 2 + TS_BYTES;
  localparam int REC_BITS = 8 * REC_LEN;
  localparam int DEPTH    = 2 ** DEPTH_BITS;
  localparam int IDX_W    = $clog2(REC_LEN);
  localparam logic [DEPTH_BITS:0] FULL = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_LEN - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [REC_BITS-1:0]   mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  lost;
  state_t                state;
  logic [REC_BITS-1:0]   shift;
  logic [IDX_W-1:0]      idx;
  logic [REC_BITS-1:0]   new_rec;
  logic [REC_BITS-1:0]   head_rec;
  logic                  accept;
  logic                  do_push;
  logic                  do_pop;
  logic                  last_byte;

`ifdef LPC_CAPTURE_TIMESTAMP_EN
  logic [15:0] ts;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ts <= 16'h0000;
    else        ts <= ts + 16'h0001;
  end

  assign new_rec = {lost, 3'b000, in_cyctype, in_addr[8*ADDR_BYTES-1:0], in_data, ts};
`else
  assign new_rec = {lost, 3'b000, in_cyctype, in_addr[8*ADDR_BYTES-1:0], in_data};
`endif

  assign accept    = capture_en && in_latch && TYPE_MASK[in_cyctype];
  // Fullness uses the count from the start of the cycle; a same-edge pop never makes room.
  assign do_push   = accept && (count != FULL);
  assign last_byte = (idx == LAST_IDX);
  assign do_pop    = (count != '0) &&
                     ((state == S_IDLE) || (out_valid && out_ready && last_byte));
  assign head_rec  = mem[rd_ptr];
  assign empty     = (count == '0) && (state == S_IDLE);
  assign overflow  = lost;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= new_rec;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      lost       <= 1'b0;
      drop_count <= 16'h0000;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (do_push) begin
        lost <= 1'b0;
      end else if (accept) begin
        lost <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'h0001;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      shift     <= '0;
      idx       <= '0;
    end else if (do_pop) begin
      state     <= S_SEND;
      out_valid <= 1'b1;
      out_data  <= head_rec[REC_BITS-1 -: 8];
      shift     <= head_rec << 8;
      idx       <= '0;
    end else if (state == S_SEND && out_ready) begin
      if (last_byte) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
      end else begin
        out_data <= shift[REC_BITS-1 -: 8];
        shift    <= shift << 8;
        idx      <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lpc_capture_fifo.sv
// tb/tb_lpc_capture_fifo.sv - randomized and directed bench for lpc_capture_fifo against a byte-queue model
module tb_lpc_capture_fifo;

`ifdef LPC_CAPTURE_TIMESTAMP_EN
  localparam int AB  = 2;
  localparam int TSB = 2;
`else
  localparam int AB  = 4;
  localparam int TSB = 0;
`endif
  localparam int          DB    = 2;
  localparam int          DEPTH = 4;
  localparam logic [15:0] TM    = 16'h7FFD;
  localparam int          RL    = AB + 2 + TSB;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        capture_en = 1'b0;
  logic [3:0]  in_cyctype = 4'h0;
  logic [31:0] in_addr = 32'h0;
  logic [7:0]  in_data = 8'h0;
  logic        in_latch = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        empty;
  logic        overflow;
  logic [15:0] drop_count;

  lpc_capture_fifo #(.ADDR_BYTES(AB), .DEPTH_BITS(DB), .TYPE_MASK(TM)) dut (
    .clock(clock), .reset(reset), .capture_en(capture_en), .in_cyctype(in_cyctype),
    .in_addr(in_addr), .in_data(in_data), .in_latch(in_latch), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .empty(empty), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Model: queued record bytes (RL per record), bytes still to emit from the serializer.
  logic [7:0]  mq [$];
  logic [7:0]  mcur [$];
  logic        mlost = 1'b0;
  logic [15:0] mdrop = 16'h0;
  logic [15:0] mts = 16'h0;
  logic [7:0]  rb [RL];
  logic [7:0]  got [$];
  logic [7:0]  exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic build_rec(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d,
                           input logic l, input logic [15:0] t);
    rb[0] = {l, 3'b000, ct};
    for (int i = 0; i < AB; i++) rb[1+i] = a[8*(AB-1-i) +: 8];
    rb[1+AB] = d;
`ifdef LPC_CAPTURE_TIMESTAMP_EN
    rb[2+AB] = t[15:8];
    rb[3+AB] = t[7:0];
`endif
  endtask

  task automatic model_edge();
    int pc;
    pc = mq.size() / RL;
    if (capture_en && in_latch && TM[in_cyctype]) begin
      if (pc < DEPTH) begin
        build_rec(in_cyctype, in_addr, in_data, mlost, mts);
        for (int i = 0; i < RL; i++) mq.push_back(rb[i]);
        mlost = 1'b0;
      end else begin
        mlost = 1'b1;
        if (mdrop != 16'hFFFF) mdrop = mdrop + 16'h1;
      end
    end
    if (mcur.size() > 0 && out_ready) void'(mcur.pop_front());
    if (mcur.size() == 0 && pc > 0)
      for (int i = 0; i < RL; i++) mcur.push_back(mq.pop_front());
    mts = mts + 16'h1;
  endtask

  task automatic check_outputs();
    check_eq("out_valid", out_valid, mcur.size() > 0);
    if (mcur.size() > 0) check_eq("out_data", out_data, mcur[0]);
    check_eq("empty", empty, (mq.size() == 0) && (mcur.size() == 0));
    check_eq("overflow", overflow, mlost);
    check_eq("drop_count", drop_count, mdrop);
  endtask

  task automatic step();
    if (reset && out_valid && out_ready) got.push_back(out_data);
    @(posedge clock);
    if (reset) model_edge();
    #1;
    check_outputs();
  endtask

  task automatic strobe(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d);
    capture_en = 1'b1;
    in_cyctype = ct;
    in_addr = a;
    in_data = d;
    in_latch = 1'b1;
    step();
    in_latch = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mq.delete();
    mcur.delete();
    mlost = 1'b0;
    mdrop = 16'h0;
    mts = 16'h0;
    #1;
    check_outputs();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic compare_got(input string tag);
    check_eq({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) check_eq(tag, got[i], exp_q[i]);
  endtask

  initial begin
    logic [31:0] ra;
    logic [7:0]  rd;
`ifndef LPC_CAPTURE_TIMESTAMP_EN
    logic [7:0] lit [6];
`endif
    #2;
    do_reset();
    check_eq("rst_drop_count", drop_count, 32'h0);
    repeat (2) step();

    // single record, free-flowing consumer
    out_ready = 1'b1;
    got.delete();
    exp_q.delete();
    build_rec(4'h2, 32'h80, 8'h5A, 1'b0, mts);
    for (int i = 0; i < RL; i++) exp_q.push_back(rb[i]);
    strobe(4'h2, 32'h0000_0080, 8'h5A);
    check_eq("t1_not_yet_valid", out_valid, 32'h0);
    step();
    check_eq("t1_header_next_edge", out_valid, 32'h1);
    repeat (RL + 2) step();
    compare_got("t1_bytes");
`ifndef LPC_CAPTURE_TIMESTAMP_EN
    lit = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h80, 8'h5A};
    for (int i = 0; i < 6 && i < got.size(); i++) check_eq("t1_literal", got[i], lit[i]);
`endif
    check_eq("t1_empty", empty, 32'h1);

    // type filter: cyctype 1 is masked out
    got.delete();
    strobe(4'h1, 32'h11, 8'h11);
    strobe(4'h2, 32'h22, 8'h22);
    repeat (RL + 4) step();
    check_eq("filt_len", got.size(), RL);
    if (got.size() > 0) check_eq("filt_hdr", got[0], 32'h02);
    check_eq("filt_drops", drop_count, 32'h0);

    // overflow: 4 in FIFO + 1 in serializer, two drops
    out_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 7; i++) strobe(4'h2, 32'h100 + i, 8'(i));
    check_eq("ovf_drops", drop_count, 32'h2);
    check_eq("ovf_flag", overflow, 32'h1);
    out_ready = 1'b1;
    repeat (RL + 2) step();
    strobe(4'h3, 32'h200, 8'hC3);
    repeat (6 * RL + 10) step();
    check_eq("ovf_len", got.size(), 6 * RL);
    for (int k = 0; k < 6 && k * RL < got.size(); k++)
      check_eq("ovf_lost_bit", got[k*RL][7], (k == 5));
    check_eq("ovf_cleared", overflow, 32'h0);

    // reset in the middle of a record
    strobe(4'h2, 32'hDEAD_BEEF, 8'h44);
    repeat (4) step();
    check_eq("mid_valid_before", out_valid, 32'h1);
    do_reset();
    check_eq("mid_valid", out_valid, 32'h0);
    check_eq("mid_empty", empty, 32'h1);
    check_eq("mid_drops", drop_count, 32'h0);
    got.delete();
    exp_q.delete();
    build_rec(4'h5, 32'hA5A5_0001, 8'h77, 1'b0, mts);
    for (int i = 0; i < RL; i++) exp_q.push_back(rb[i]);
    strobe(4'h5, 32'hA5A5_0001, 8'h77);
    repeat (RL + 4) step();
    compare_got("mid_clean");

    // three back-to-back records with a randomly stalling consumer
    got.delete();
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      ra = $urandom;
      rd = 8'($urandom);
      build_rec(4'h2, ra, rd, 1'b0, mts);
      for (int i = 0; i < RL; i++) exp_q.push_back(rb[i]);
      out_ready = 1'($urandom);
      strobe(4'h2, ra, rd);
    end
    for (int c = 0; c < 80; c++) begin
      out_ready = 1'($urandom);
      step();
    end
    out_ready = 1'b1;
    repeat (3 * RL + 4) step();
    compare_got("stall_stream");

    // free-running random traffic, including masked types and disabled capture
    for (int c = 0; c < 400; c++) begin
      capture_en = ($urandom_range(0, 7) != 0);
      in_latch = ($urandom_range(0, 2) == 0);
      in_cyctype = 4'($urandom);
      in_addr = $urandom;
      in_data = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_latch = 1'b0;
    out_ready = 1'b1;
    repeat (6 * RL + 4) step();
    check_eq("rand_drained", empty, 32'h1);

`ifdef LPC_CAPTURE_TIMESTAMP_EN
    do_reset();
    for (int c = 0; c < 400 && mts != 16'h0123; c++) step();
    check_eq("ts_reached", mts, 32'h0123);
    got.delete();
    exp_q.delete();
    exp_q = '{8'h02, 8'h00, 8'h80, 8'h5A, 8'h01, 8'h23};
    strobe(4'h2, 32'h0000_0080, 8'h5A);
    repeat (RL + 4) step();
    compare_got("ts_record");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
